cbus_arbiter: RTL



---
 rtl/cbus_arbiter_pkg.sv | 40 ++++
 rtl/cbus_arbiter_if.sv | 31 +++
 rtl/cbus_arbiter_pick.sv | 30 +++
 rtl/cbus_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types, arbiter state encoding and defaults.
// Imported by the interface, the picker and the arbiter top.
package cbus_arbiter_pkg;

    parameter int CBUS_NUM_MASTERS = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } cbus_arb_state_t;

    // Burst length in AXI encoding (beats - 1)
    typedef enum logic [7:0] {
        MLEN1  = 8'd0,
        MLEN2  = 8'd1,
        MLEN4  = 8'd3,
        MLEN8  = 8'd7,
        MLEN16 = 8'd15
    } cbus_len_t;

    // 151 bits
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        cbus_len_t   len;
        logic [1:0]  burst;
    } cbus_req_t;

    // 66 bits
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of cache-bus signals around the arbiter.
// slave: arbiter side; master: masters + bridge side.
interface cbus_arbiter_if
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = CBUS_NUM_MASTERS
);

    cbus_req_t  ireqs  [NUM_MASTERS];
    cbus_resp_t oresps [NUM_MASTERS];
    cbus_req_t  oreq;
    cbus_resp_t iresp;
    logic       busy;

    modport slave (
        input  ireqs,
        input  iresp,
        output oresps,
        output oreq,
        output busy
    );

    modport master (
        output ireqs,
        output iresp,
        input  oresps,
        input  oreq,
        input  busy
    );

endinterface

// File: rtl/cbus_arbiter_pick.sv
// Combinational winner search over a valid vector.
// Ports: valid, start -> winner, any_valid (search wraps from start).
module cbus_arb_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] start,
    output logic [$clog2(N)-1:0] winner,
    output logic                 any_valid
);

    localparam int SB = $clog2(N);

    int idx;

    // Walk from farthest to nearest so the nearest valid index
    // starting at 'start' is the last one written.
    always_comb begin
        idx       = 0;
        winner    = '0;
        any_valid = |valid;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            if (valid[idx]) begin
                winner = SB'(idx);
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Burst-granular arbiter sharing one cbus port between NUM_MASTERS.
// Ports: clk, reset (sync, active-high), bus (slave modport):
//   ireqs/oresps per master, oreq/iresp to bridge, busy.
// Macro CBUS_ARB_RR_EN: round-robin instead of fixed priority.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = CBUS_NUM_MASTERS
) (
    input  logic          clk,
    input  logic          reset,
    cbus_arbiter_if.slave bus
);

    localparam int SEL_BITS = $clog2(NUM_MASTERS);

    cbus_arb_state_t       state;
    cbus_arb_state_t       state_n;
    logic [SEL_BITS-1:0]   sel;
    logic [SEL_BITS-1:0]   sel_n;
    logic [SEL_BITS-1:0]   start;
    logic [SEL_BITS-1:0]   winner;
    logic [NUM_MASTERS-1:0] valid_vec;
    logic                  any_valid;
    logic                  done;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            valid_vec[i] = bus.ireqs[i].valid;
        end
    end

    assign done = bus.iresp.ready && bus.iresp.last;

`ifdef CBUS_ARB_RR_EN
    logic [SEL_BITS-1:0] rr;

    // Next search starts just past the master that finished.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr <= '0;
        end else if (state == ARB_BUSY && done) begin
            if (sel == SEL_BITS'(NUM_MASTERS - 1)) begin
                rr <= '0;
            end else begin
                rr <= sel + 1'b1;
            end
        end
    end

    assign start = rr;
`else
    assign start = '0;
`endif

    cbus_arb_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .valid     (valid_vec),
        .start     (start),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            sel   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
        end
    end

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        bus.oreq = '0;
        bus.busy = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            bus.oresps[j] = '0;
        end

        unique case (state)
            ARB_IDLE: begin
                // Grant is registered: no valid->oreq path here.
                if (any_valid) begin
                    state_n = ARB_BUSY;
                    sel_n   = winner;
                end
            end
            ARB_BUSY: begin
                bus.oreq        = bus.ireqs[sel];
                bus.oresps[sel] = bus.iresp;
                bus.busy        = 1'b1;
                if (done) begin
                    state_n = ARB_IDLE;
                end
            end
        endcase

        // Outputs are quiet in the reset cycle itself.
        if (reset) begin
            bus.oreq = '0;
            bus.busy = 1'b0;
            for (int j = 0; j < NUM_MASTERS; j++) begin
                bus.oresps[j] = '0;
            end
        end
    end

endmodule
